// File: rtl/mem_req_master.sv
// mem_req_master: valid/ready request initiator for the 4-bit data memory; define MEM_TIMEOUT_EN to abort unacknowledged accesses
module mem_req_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4
`ifdef MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 15
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic              rsp_wr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  input  logic [DATA_W-1:0] mem_q,
  input  logic              mem_ack,
  output logic [7:0]        xfer_cnt
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state, state_n;
  logic acc, ack, tmo, done;
  logic mem_wr_n, rsp_wr_n;
  logic [ADDR_W-1:0] mem_a_n;
  logic [DATA_W-1:0] mem_d_n, rsp_rdata_n;
  logic [7:0] xfer_cnt_n;
  assign acc = state == IDLE && req_valid;
  assign ack = state == ISSUE && mem_ack;
  assign done = ack || tmo;
`ifdef MEM_TIMEOUT_EN
  logic [7:0] wcnt;
  assign tmo = state == ISSUE && !mem_ack && wcnt == 8'(TIMEOUT_CYCLES - 1);
  // wait counter runs only while issuing and is zero on every ISSUE entry; error flag marks the aborted response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wcnt    <= '0;
      rsp_err <= 1'b0;
    end else begin
      wcnt    <= state == ISSUE ? wcnt + 8'd1 : 8'd0;
      rsp_err <= tmo;
    end
`else
  assign tmo = 1'b0;
  assign rsp_err = 1'b0;
`endif
  // next state and next values of every registered output; request fields are cleared once the access completes
  always_comb begin
    state_n     = acc ? ISSUE : done ? RESP : state == RESP ? IDLE : state;
    mem_wr_n    = acc ? req_wr : done ? 1'b0 : mem_wr;
    mem_a_n     = acc ? req_addr : done ? '0 : mem_a;
    mem_d_n     = acc ? (req_wr ? req_wdata : '0) : done ? '0 : mem_d;
    rsp_wr_n    = done ? mem_wr : 1'b0;
    rsp_rdata_n = ack && !mem_wr ? mem_q : rsp_rdata;
    xfer_cnt_n  = state == RESP ? xfer_cnt + 8'd1 : xfer_cnt;
  end
  // state and outputs all come straight from flops so nothing combinational reaches the pins
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      mem_en    <= 1'b0;
      rsp_valid <= 1'b0;
      mem_wr    <= 1'b0;
      mem_a     <= '0;
      mem_d     <= '0;
      rsp_wr    <= 1'b0;
      rsp_rdata <= '0;
      xfer_cnt  <= '0;
    end else begin
      state     <= state_n;
      req_ready <= state_n == IDLE;
      mem_en    <= state_n == ISSUE;
      rsp_valid <= state_n == RESP;
      mem_wr    <= mem_wr_n;
      mem_a     <= mem_a_n;
      mem_d     <= mem_d_n;
      rsp_wr    <= rsp_wr_n;
      rsp_rdata <= rsp_rdata_n;
      xfer_cnt  <= xfer_cnt_n;
    end
endmodule
